// File: rtl/light_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | light_pkg                                                        |
// | Shared types and colour constants for the status-LED blocks.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package light_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2
  } arb_state_t;

  // Colours are active-high {r,g,b}; the pin driver inverts them.
  localparam logic [2:0] RGB_OFF = 3'b111;
  localparam logic [2:0] C_RED   = 3'b100;
  localparam logic [2:0] C_GREEN = 3'b010;
  localparam logic [2:0] C_BLUE  = 3'b001;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_pick                                                          |
// | Combinational round-robin picker: first set req bit at or after  |
// | pointer, searching upward and wrapping to 0.                     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] pointer,
  output logic [PTR_W-1:0] winner,
  output logic             valid
);

  logic [PTR_W-1:0] w_idx;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    winner = '0;
    valid  = |req;
    w_idx  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_idx = PTR_W'((int'(pointer) + i) % N_REQ);
      if (req[w_idx]) begin
        winner = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rgb_led_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rgb_led_arbiter                                                  |
// | Round-robin sharing of one active-low RGB LED among N_REQ status |
// | requesters, with a fixed dwell per grant and an off gap after.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rgb_led_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DWELL_TICKS = 12_000_000,
  parameter int GAP_TICKS   = 1_200_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [3*N_REQ-1:0]   color,
  output logic [N_REQ-1:0]     grant,
  output logic                 done,
  output logic                 busy,
  output logic [2:0]           rgb
);
  import light_pkg::*;

  localparam int C_PTR_W     = $clog2(N_REQ);
  localparam int C_MAX_TICKS = max_int(DWELL_TICKS, GAP_TICKS);
  localparam int C_CNT_W     = $clog2(C_MAX_TICKS + 1);

  arb_state_t         r_state;
  arb_state_t         w_next_state;
  logic [C_PTR_W-1:0] r_ptr;
  logic [C_PTR_W-1:0] r_winner;
  logic [2:0]         r_color;
  logic [C_CNT_W-1:0] r_cnt;

  logic [C_PTR_W-1:0] w_pick_idx;
  logic               w_pick_valid;
  logic [2:0]         w_pick_color;
  logic [C_PTR_W-1:0] w_ptr_next;
  logic [N_REQ-1:0]   w_onehot;
  logic               w_dwell_last;
  logic               w_gap_last;
  logic               w_exit_show;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (C_PTR_W)
  ) u_pick (
    .req     (req),
    .pointer (r_ptr),
    .winner  (w_pick_idx),
    .valid   (w_pick_valid)
  );

  always_comb begin
    w_pick_color = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_idx == C_PTR_W'(i)) begin
        w_pick_color = color[3*i +: 3];
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
    assign w_onehot[gi] = (r_winner == C_PTR_W'(gi));
  end

  assign w_dwell_last = (r_cnt == C_CNT_W'(DWELL_TICKS - 1));
  assign w_gap_last   = (r_cnt == C_CNT_W'(GAP_TICKS - 1));
  // A dropped request ends the show early; the dwell counter alone decides done.
  assign w_exit_show  = w_dwell_last || !req[r_winner];
  assign w_ptr_next   = (r_winner == C_PTR_W'(N_REQ - 1)) ? '0 : r_winner + C_PTR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_pick_valid) w_next_state = S_SHOW;
      S_SHOW: if (w_exit_show)  w_next_state = (GAP_TICKS == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (w_gap_last)   w_next_state = S_IDLE;
      default:                  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_winner <= '0;
      r_color  <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_valid) begin
            r_winner <= w_pick_idx;
            r_color  <= w_pick_color;
            r_cnt    <= '0;
          end
        end
        S_SHOW: begin
          if (w_exit_show) begin
            r_ptr <= w_ptr_next;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + C_CNT_W'(1);
          end
        end
        S_GAP: begin
          r_cnt <= w_gap_last ? '0 : r_cnt + C_CNT_W'(1);
        end
        default: begin
          r_winner <= '0;
          r_color  <= '0;
          r_cnt    <= '0;
        end
      endcase
    end
  end

  always_comb begin
    grant = '0;
    done  = 1'b0;
    busy  = 1'b0;
    rgb   = RGB_OFF;
    case (r_state)
      S_SHOW: begin
        grant = w_onehot;
        rgb   = ~r_color;
        done  = w_dwell_last;
        busy  = 1'b1;
      end
      S_GAP: begin
        busy  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_rgb_led_arbiter                                               |
// | Vector-table bench for rgb_led_arbiter (gap=2 and gap=0 builds). |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_rgb_led_arbiter;
  import light_pkg::*;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [11:0] col;
    logic [3:0]  g;
    logic [2:0]  o;
    logic        d;
    logic        b;
    bit          use_b;
    bit          chk;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] color;
  logic [3:0]  grant_a, grant_b;
  logic        done_a, done_b, busy_a, busy_b;
  logic [2:0]  rgb_a, rgb_b;

  vec_t        tbl[$];
  vec_t        exp_q[$];
  logic [11:0] cur_col;
  bit          cur_b;
  int          n_checks = 0;
  int          n_fail   = 0;

  localparam logic [11:0] COL_A = {3'b110, C_BLUE, C_RED, C_GREEN};
  localparam logic [11:0] COL_B = {3'b000, 3'b000, C_GREEN, 3'b000};

  always #5 clk = ~clk;

  rgb_led_arbiter #(.N_REQ(4), .DWELL_TICKS(4), .GAP_TICKS(2)) dut_a (
    .clk(clk), .rst(rst), .req(req), .color(color),
    .grant(grant_a), .done(done_a), .busy(busy_a), .rgb(rgb_a)
  );

  rgb_led_arbiter #(.N_REQ(4), .DWELL_TICKS(4), .GAP_TICKS(0)) dut_b (
    .clk(clk), .rst(rst), .req(req), .color(color),
    .grant(grant_b), .done(done_b), .busy(busy_b), .rgb(rgb_b)
  );

  task automatic row(input logic r, input logic [3:0] q, input logic [3:0] g,
                     input logic [2:0] o, input logic d, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.col = cur_col; v.g = g; v.o = o; v.d = d; v.b = b;
    v.use_b = cur_b; v.chk = 1'b1;
    tbl.push_back(v);
  endtask

  task automatic rst_row();
    vec_t v;
    v.rst = 1'b1; v.req = '0; v.col = cur_col; v.g = '0; v.o = RGB_OFF;
    v.d = 1'b0; v.b = 1'b0; v.use_b = cur_b; v.chk = 1'b0;
    tbl.push_back(v);
  endtask

  task automatic idle(input int n, input logic [3:0] q);
    for (int k = 0; k < n; k++) row(1'b0, q, 4'b0000, 3'b111, 1'b0, 1'b0);
  endtask

  task automatic show(input logic [3:0] q, input logic [3:0] g, input logic [2:0] o);
    for (int k = 0; k < 4; k++) row(1'b0, q, g, o, (k == 3), 1'b1);
  endtask

  task automatic gap(input logic [3:0] q);
    for (int k = 0; k < 2; k++) row(1'b0, q, 4'b0000, 3'b111, 1'b0, 1'b1);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    cur_col = COL_A;
    cur_b   = 1'b0;

    rst_row(); rst_row();
    idle(10, 4'b0000);
    // single requester 1: show, gap, one idle, show again
    idle(1, 4'b0010);
    show(4'b0010, 4'b0010, 3'b011);
    gap(4'b0010);
    idle(1, 4'b0010);
    cur_col = COL_B;
    show(4'b0010, 4'b0010, 3'b011);
    cur_col = COL_A;
    row(1'b1, 4'b0000, 4'b0000, 3'b111, 1'b0, 1'b1);
    // fairness from pointer 0
    idle(1, 4'b1111);
    show(4'b1111, 4'b0001, 3'b101); gap(4'b1111); idle(1, 4'b1111);
    show(4'b1111, 4'b0010, 3'b011); gap(4'b1111); idle(1, 4'b1111);
    show(4'b1111, 4'b0100, 3'b110); gap(4'b1111); idle(1, 4'b1111);
    show(4'b1111, 4'b1000, 3'b001); gap(4'b1111); idle(1, 4'b1111);
    show(4'b1111, 4'b0001, 3'b101); gap(4'b0100); idle(1, 4'b0100);
    // abort on the second show cycle of requester 2
    row(1'b0, 4'b0100, 4'b0100, 3'b110, 1'b0, 1'b1);
    row(1'b0, 4'b1001, 4'b0100, 3'b110, 1'b0, 1'b1);
    gap(4'b1001); idle(1, 4'b1001);
    // requester 3 wins over 0; reset on its third show cycle
    row(1'b0, 4'b1001, 4'b1000, 3'b001, 1'b0, 1'b1);
    row(1'b0, 4'b1001, 4'b1000, 3'b001, 1'b0, 1'b1);
    row(1'b1, 4'b1100, 4'b1000, 3'b001, 1'b0, 1'b1);
    idle(1, 4'b1100);
    show(4'b1100, 4'b0100, 3'b110);
    // zero-gap build
    cur_b = 1'b1;
    rst_row();
    idle(1, 4'b0001);
    show(4'b0001, 4'b0001, 3'b101);
    idle(1, 4'b0001);
    show(4'b0001, 4'b0001, 3'b101);
    idle(3, 4'b0000);

    rst = 1'b1; req = '0; color = COL_A;
    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      rst   = tbl[i].rst;
      req   = tbl[i].req;
      color = tbl[i].col;
      exp_q.push_back(tbl[i]);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard row %0d: got empty queue, expected an entry", i);
      end else begin
        e = exp_q.pop_front();
        if (e.chk) begin
          if (e.use_b) begin
            check("grant_b", i, {4'b0, grant_b}, {4'b0, e.g});
            check("rgb_b",   i, {5'b0, rgb_b},   {5'b0, e.o});
            check("done_b",  i, {7'b0, done_b},  {7'b0, e.d});
            check("busy_b",  i, {7'b0, busy_b},  {7'b0, e.b});
          end else begin
            check("grant_a", i, {4'b0, grant_a}, {4'b0, e.g});
            check("rgb_a",   i, {5'b0, rgb_a},   {5'b0, e.o});
            check("done_a",  i, {7'b0, done_a},  {7'b0, e.d});
            check("busy_a",  i, {7'b0, busy_a},  {7'b0, e.b});
          end
        end
      end
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
